// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART datapath.
//   parity_mode_e  - decoded parity selection (raw code 3 folds onto PAR_NONE)
//   rx_state_e     - receiver FSM states
//   samp_lo/mid/hi - oversample tick indices of the three majority-vote
//                    samples, centred on the middle of a bit of OSR ticks
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BRK_WAIT
  } rx_state_e;

  localparam int OSR_DEFAULT = 16;

  function automatic int samp_lo(input int osr);
    return osr / 2 - 1;
  endfunction

  function automatic int samp_mid(input int osr);
    return osr / 2;
  endfunction

  function automatic int samp_hi(input int osr);
    return osr / 2 + 1;
  endfunction

  localparam int SAMP_LO_DEFAULT  = samp_lo(OSR_DEFAULT);
  localparam int SAMP_MID_DEFAULT = samp_mid(OSR_DEFAULT);
  localparam int SAMP_HI_DEFAULT  = samp_hi(OSR_DEFAULT);

  function automatic parity_mode_e decode_parity(input logic [1:0] code);
    case (code)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running oversample tick generator.
//   clk, rst - clock and synchronous active-high reset
//   clr      - restart the period so the next cycle carries a tick
//   dvsr     - period minus one; tick asserts once every dvsr+1 clocks
//   tick     - high while the counter sits at zero
module baud_tick_gen #(
  parameter int DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  tick
);

  logic [DVSR_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (cnt_reg == dvsr) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DVSR_WIDTH'(1);
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with majority-vote sampling.
//   clk, rst          - clock, synchronous active-high reset
//   en                - receiver enable; low abandons any frame in progress
//   dvsr              - oversample tick period minus one
//   data_bits         - character width, clamped to 5..MAX_DATA_BITS
//   parity_mode       - 0/3 none, 1 even, 2 odd
//   stop_bits         - 0 one stop bit, 1 two
//   rx                - asynchronous serial input, idle high
//   dout/dout_valid   - holding register and its full flag
//   dout_ready        - consumer accept
//   parity_err        - sideband of the held character
//   frame_err         - sideband of the held character
//   overrun_err       - pulse: character dropped because holding was full
//   break_det         - pulse: break frame recognised
//   busy              - receiver FSM away from IDLE
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int OSR           = 16,
  parameter int DVSR_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DVSR_WIDTH-1:0]    dvsr,
  input  logic [3:0]               data_bits,
  input  logic [1:0]               parity_mode,
  input  logic                     stop_bits,
  input  logic                     rx,
  output logic [MAX_DATA_BITS-1:0] dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun_err,
  output logic                     break_det,
  output logic                     busy
);

  localparam int SW = $clog2(OSR);
  localparam logic [SW-1:0] S_LO  = SW'(samp_lo(OSR));
  localparam logic [SW-1:0] S_MID = SW'(samp_mid(OSR));
  localparam logic [SW-1:0] S_HI  = SW'(samp_hi(OSR));
  localparam logic [SW-1:0] S_END = SW'(OSR - 1);

  logic [1:0]               sync_reg;
  logic                     prev_reg;
  rx_state_e                state_reg;
  logic [SW-1:0]            s_reg;
  logic [3:0]               bit_reg;
  logic [3:0]               width_reg;
  parity_mode_e             par_reg;
  logic                     two_stop_reg;
  logic [MAX_DATA_BITS-1:0] data_reg;
  logic                     par_bit_reg;
  logic                     perr_frame_reg;
  logic [1:0]               samp_reg;
  logic                     hi_reg;
  logic [MAX_DATA_BITS-1:0] dout_reg;
  logic                     valid_reg;
  logic                     perr_reg;
  logic                     ferr_reg;
  logic                     ovr_reg;
  logic                     brk_reg;
  logic                     busy_reg;
  logic                     loaded_reg;

  logic                     rx_s;
  logic                     rx_fall;
  logic                     start_go;
  logic                     tick;
  logic                     vote;
  logic                     accept;
  logic                     par_exp;
  logic [3:0]               width_cl;

  // Two-stage synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b11;
      prev_reg <= 1'b1;
    end else begin
      sync_reg <= {sync_reg[0], rx};
      prev_reg <= sync_reg[1];
    end
  end

  assign rx_s     = sync_reg[1];
  assign rx_fall  = prev_reg & ~rx_s;
  assign start_go = (state_reg == ST_IDLE) && en && rx_fall;

  // Restarting the tick counter on the start edge makes tick 0 land on the
  // very next cycle, so bit boundaries are phase-locked to the falling edge.
  baud_tick_gen #(
    .DVSR_WIDTH(DVSR_WIDTH)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (start_go),
    .dvsr(dvsr),
    .tick(tick)
  );

  always_comb begin
    width_cl = data_bits;
    if (data_bits < 4'd5) begin
      width_cl = 4'd5;
    end else if (data_bits > 4'(MAX_DATA_BITS)) begin
      width_cl = 4'(MAX_DATA_BITS);
    end
  end

  // Third sample is the live synced line on the S_HI tick.
  assign vote    = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);
  assign accept  = valid_reg & dout_ready;
  // Upper bits of data_reg stay zero, so the full-width XOR is the char parity.
  assign par_exp = (par_reg == PAR_ODD) ? ~(^data_reg) : (^data_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      s_reg          <= '0;
      bit_reg        <= '0;
      width_reg      <= 4'd8;
      par_reg        <= PAR_NONE;
      two_stop_reg   <= 1'b0;
      data_reg       <= '0;
      par_bit_reg    <= 1'b0;
      perr_frame_reg <= 1'b0;
      samp_reg       <= 2'b11;
      hi_reg         <= 1'b0;
      dout_reg       <= '0;
      valid_reg      <= 1'b0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
      ovr_reg        <= 1'b0;
      brk_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      loaded_reg     <= 1'b0;
    end else begin
      ovr_reg <= 1'b0;
      brk_reg <= 1'b0;
      if (accept) begin
        valid_reg  <= 1'b0;
        loaded_reg <= 1'b0;
      end
      if (tick) begin
        s_reg <= (s_reg == S_END) ? '0 : s_reg + SW'(1);
        if (s_reg == S_LO)  samp_reg[0] <= rx_s;
        if (s_reg == S_MID) samp_reg[1] <= rx_s;
      end

      if (!en) begin
        state_reg <= ST_IDLE;
        busy_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (rx_fall) begin
              state_reg      <= ST_START;
              busy_reg       <= 1'b1;
              s_reg          <= '0;
              width_reg      <= width_cl;
              par_reg        <= decode_parity(parity_mode);
              two_stop_reg   <= stop_bits;
              data_reg       <= '0;
              par_bit_reg    <= 1'b0;
              perr_frame_reg <= 1'b0;
            end
          end
          ST_START: begin
            if (tick && s_reg == S_HI && vote) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end else if (tick && s_reg == S_END) begin
              state_reg <= ST_DATA;
              bit_reg   <= '0;
            end
          end
          ST_DATA: begin
            if (tick && s_reg == S_HI) begin
              data_reg[bit_reg] <= vote;
            end
            if (tick && s_reg == S_END) begin
              if (bit_reg == width_reg - 4'd1) begin
                state_reg <= (par_reg == PAR_NONE) ? ST_STOP1 : ST_PARITY;
              end else begin
                bit_reg <= bit_reg + 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (tick && s_reg == S_HI) begin
              par_bit_reg    <= vote;
              perr_frame_reg <= (vote != par_exp);
            end
            if (tick && s_reg == S_END) begin
              state_reg <= ST_STOP1;
            end
          end
          ST_STOP1: begin
            // Leave at the vote sample rather than the bit end so a start bit
            // arriving early is still caught.
            if (tick && s_reg == S_HI) begin
              if (data_reg == '0 && (par_reg == PAR_NONE || !par_bit_reg) && !vote) begin
                brk_reg   <= 1'b1;
                hi_reg    <= 1'b0;
                state_reg <= ST_BRK_WAIT;
              end else begin
                if (!valid_reg || accept) begin
                  dout_reg   <= data_reg;
                  valid_reg  <= 1'b1;
                  perr_reg   <= perr_frame_reg;
                  ferr_reg   <= ~vote;
                  loaded_reg <= 1'b1;
                end else begin
                  ovr_reg <= 1'b1;
                end
                if (two_stop_reg) begin
                  state_reg <= ST_STOP2;
                  bit_reg   <= '0;
                end else begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
                end
              end
            end
          end
          ST_STOP2: begin
            // bit_reg flags that the second stop bit period has begun.
            if (tick && s_reg == S_END) begin
              bit_reg <= 4'd1;
            end
            if (tick && s_reg == S_HI && bit_reg == 4'd1) begin
              if (!vote && loaded_reg && valid_reg && !accept) begin
                ferr_reg <= 1'b1;
              end
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
            end
          end
          ST_BRK_WAIT: begin
            // Exit only after the line has been high across a whole tick period.
            if (!rx_s) begin
              hi_reg <= 1'b0;
            end else if (tick) begin
              if (hi_reg) begin
                state_reg <= ST_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                hi_reg <= 1'b1;
              end
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout        = dout_reg;
  assign dout_valid  = valid_reg;
  assign parity_err  = perr_reg;
  assign frame_err   = ferr_reg;
  assign overrun_err = ovr_reg;
  assign break_det   = brk_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

  localparam int OSR = 16;
  localparam int DV  = 3;
  localparam int B   = (DV + 1) * OSR;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] dvsr = 16'(DV);
  logic [3:0]  data_bits = 4'd8;
  logic [1:0]  parity_mode = 2'd0;
  logic        stop_bits = 1'b0;
  logic        rx = 1'b1;
  logic [8:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        parity_err, frame_err, overrun_err, break_det, busy;

  uart_rx_cfg #(.MAX_DATA_BITS(9), .OSR(OSR), .DVSR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .dvsr(dvsr), .data_bits(data_bits),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .rx(rx),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 character delivered, 1 break pulse, 2 overrun pulse
  typedef struct {
    int         kind;
    int         cyc;
    int         c0;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         last_lat = -1;
  logic [8:0] held = '0;
  logic       held_pe = 1'b0;
  logic       held_fe = 1'b0;
  logic       pv = 1'b0, pbk = 1'b0, pov = 1'b0;

  int         tw;
  bit         tpen;
  logic       tpb;
  logic [8:0] td;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Model: what the receiver must report for a frame whose start bit is put
  // on the line at bench cycle c0.
  task automatic push_exp(input logic [8:0] data, input int dbits, input int pm, input int c0,
                          input bit bad_par, input bit stop1, input bit ovr,
                          output int w, output bit pen, output logic pb, output logic [8:0] d);
    ev_t        e;
    logic [8:0] mask;
    logic       good;
    int         g;
    w    = (dbits < 5) ? 5 : ((dbits > 9) ? 9 : dbits);
    mask = 9'((1 << w) - 1);
    d    = data & mask;
    pen  = (pm == 1) || (pm == 2);
    good = (pm == 2) ? ~(^d) : (^d);
    pb   = bad_par ? ~good : good;
    // stop-bit vote tick = (start + data + parity) bits plus the last sample
    g     = (1 + w + (pen ? 1 : 0)) * OSR + OSR / 2 + 1;
    e.c0  = c0;
    e.cyc = c0 + 4 + g * (DV + 1);
    e.d   = d;
    e.pe  = pen && (pb != good);
    e.fe  = !stop1;
    if (d == 0 && (!pen || pb == 1'b0) && !stop1) e.kind = 1;
    else if (ovr) e.kind = 2;
    else e.kind = 0;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] data, input int dbits, input int pm, input int sb,
                            input bit bad_par, input bit stop1, input bit ovr);
    int         w;
    bit         pen;
    logic       pb;
    logic [8:0] d;
    data_bits   = 4'(dbits);
    parity_mode = 2'(pm);
    stop_bits   = sb[0];
    push_exp(data, dbits, pm, cyc, bad_par, stop1, ovr, w, pen, pb, d);
    $display("frame data=%03h width=%0d parity=%0d stops=%0d stop1=%0d", d, w, pm, sb + 1, stop1);
    drive(1'b0, B);
    for (int i = 0; i < w; i++) drive(d[i], B);
    if (pen) drive(pb, B);
    drive(stop1, B);
    if (sb != 0) drive(1'b1, B);
    rx = 1'b1;
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=kind%0d required=none (cycle %0d)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == 0) begin
        chk("dout", int'(dout), int'(e.d));
        chk("parity_err", int'(parity_err), int'(e.pe));
        chk("frame_err", int'(frame_err), int'(e.fe));
        held    = dout;
        held_pe = parity_err;
        held_fe = frame_err;
      end
      last_lat = cyc - e.c0;
      $display("event kind=%0d cycle=%0d dout=%03h pe=%0d fe=%0d", kind, cyc, dout, parity_err, frame_err);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && !pv) observe(0);
      if (dout_valid && pv) chk("dout_hold", int'(dout), int'(held));
      if (break_det) begin
        observe(1);
        chk("break_width", int'(pbk), 0);
      end
      if (overrun_err) begin
        observe(2);
        chk("overrun_width", int'(pov), 0);
      end
    end
    pv  <= dout_valid;
    pbk <= break_det;
    pov <= overrun_err;
  end

  initial begin
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_perr", int'(parity_err), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun_err), 0);
    chk("rst_brk", int'(break_det), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("t1_latency", last_lat, 616);
    chk("t1_dout", int'(dout), 'h0A5);
    repeat (B) @(negedge clk);

    // 7E1 0x41 with wrong parity bit
    send_frame(9'h041, 7, 1, 0, 1'b1, 1'b1, 1'b0);
    chk("t2_dout", int'(held), 'h041);
    chk("t2_perr", int'(held_pe), 1);
    repeat (B) @(negedge clk);

    // 0.3-bit glitch
    $display("glitch");
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3_busy_start", int'(busy), 1);
    repeat (9) @(negedge clk);
    rx = 1'b1;
    repeat (2 * B) @(negedge clk);
    chk("t3_busy_after", int'(busy), 0);
    chk("t3_valid", int'(dout_valid), 0);

    // 8E1 break: low 12 bit times
    $display("break");
    data_bits = 4'd8; parity_mode = 2'd1; stop_bits = 1'b0;
    push_exp(9'h000, 8, 1, cyc, 1'b0, 1'b0, 1'b0, tw, tpen, tpb, td);
    drive(1'b0, 12 * B);
    chk("t4_busy_in_brk", int'(busy), 1);
    drive(1'b1, 24);
    chk("t4_busy_after", int'(busy), 0);
    chk("t4_valid", int'(dout_valid), 0);
    repeat (B) @(negedge clk);

    // overrun with consumer stalled
    dout_ready = 1'b0;
    send_frame(9'h011, 8, 0, 0, 1'b0, 1'b1, 1'b0);
    send_frame(9'h022, 8, 0, 0, 1'b0, 1'b1, 1'b1);
    repeat (B) @(negedge clk);
    chk("t5_dout_hold", int'(dout), 'h011);
    chk("t5_valid_hold", int'(dout_valid), 1);
    dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_valid_drop", int'(dout_valid), 0);
    chk("t5_dout_after", int'(dout), 'h011);
    repeat (B) @(negedge clk);

    // reset in the middle of DATA, then a clean 0x5A
    $display("reset mid-frame");
    data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0;
    drive(1'b0, B);
    drive(1'b0, B);
    drive(1'b1, B / 2);
    chk("t6_busy_mid", int'(busy), 1);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("t6_dout", int'(dout), 0);
    chk("t6_valid", int'(dout_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_perr", int'(parity_err), 0);
    chk("t6_ferr", int'(frame_err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(9'h05A, 8, 0, 0, 1'b0, 1'b1, 1'b0);
    chk("t6_dout_next", int'(dout), 'h05A);
    repeat (B) @(negedge clk);

    // width request 12 clamps to 9, odd parity, two stop bits
    send_frame(9'h1C3, 12, 2, 1, 1'b0, 1'b1, 1'b0);
    chk("t7_dout", int'(held), 'h1C3);
    chk("t7_latency", last_lat, 744);
    chk("t7_perr", int'(held_pe), 0);
    repeat (B) @(negedge clk);

    // width request 2 clamps to 5, stop bit low
    send_frame(9'h3F5, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (B) @(negedge clk);
    chk("t8_dout", int'(held), 'h015);
    chk("t8_ferr", int'(held_fe), 1);

    repeat (B) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
